// File: rtl/tt_store_pkg.sv
// Shared types for the store drain path: FSM states and the held store request.
package tt_store_pkg;
  localparam int STORE_DW = 32;
  localparam int STORE_AW = 48;
  localparam int STORE_BW = STORE_DW / 8;

  typedef enum logic {
    RUN     = 1'b0,
    ORD_ACK = 1'b1
  } store_drain_state_e;

  typedef struct packed {
    logic [STORE_DW-1:0] data;
    logic [STORE_AW-1:0] addr;
    logic [STORE_BW-1:0] byten;
    logic                ordered;
    logic [2:0]          ldst_sz;
  } store_req_t;
endpackage

// File: rtl/tt_store_credit_cnt.sv
// Outstanding-store counter: saturating up/down, with a sticky flag for
// acks that arrive when nothing is outstanding.
module tt_store_credit_cnt #(
  parameter int MAX   = 4,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_inc_ok;
  logic             w_dec_ok;

  assign w_inc_ok = i_inc & (r_cnt != CNT_W'(MAX));
  assign w_dec_ok = i_dec & (r_cnt != '0);

  // Count issues up and acks down; a spurious ack never wraps, it latches the error.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_inc_ok & ~w_dec_ok)      r_cnt <= r_cnt + CNT_W'(1);
      else if (~w_inc_ok & w_dec_ok) r_cnt <= r_cnt - CNT_W'(1);
      if (i_dec & (r_cnt == '0))     r_err <= 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_err = r_err;
endmodule

// File: rtl/tt_store_drain_ctrl.sv
// Store drain sequencer: FIFO pop -> 1-entry hold -> valid/ready memory request,
// with credit limiting, ordered-store serialisation and fence/hazard drains.
module tt_store_drain_ctrl
  import tt_store_pkg::*;
#(
  parameter  int DATA_WIDTH      = STORE_DW,
  parameter  int ADDR_WIDTH      = STORE_AW,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_fifo_valid,
  input  logic [DATA_WIDTH-1:0]   i_fifo_data,
  input  logic [ADDR_WIDTH-1:0]   i_fifo_addr,
  input  logic [DATA_WIDTH/8-1:0] i_fifo_byten,
  input  logic                    i_fifo_ordered,
  input  logic [2:0]              i_fifo_ldst_sz,
  input  logic                    i_fifo_empty,
  output logic                    o_fifo_rden,
  output logic                    o_exit_merge_mode,
  output logic                    o_mem_req_valid,
  input  logic                    i_mem_req_ready,
  output logic [DATA_WIDTH-1:0]   o_mem_req_data,
  output logic [ADDR_WIDTH-1:0]   o_mem_req_addr,
  output logic [DATA_WIDTH/8-1:0] o_mem_req_byten,
  output logic [2:0]              o_mem_req_ldst_sz,
  input  logic                    i_mem_ack,
  input  logic                    i_load_cmphit,
  input  logic                    i_fence_req,
  output logic                    o_fence_done,
  output logic                    o_load_stall,
  output logic [CNT_W-1:0]        o_outstanding,
  output logic                    o_idle,
  output logic                    o_err_ack
);
  store_drain_state_e r_state, w_state_nxt;
  store_req_t         r_hold;
  logic               r_hold_vld;
  logic               r_fence_pend;
  logic               r_haz_pend;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_err;
  logic               w_run;
  logic               w_cnt_zero;
  logic               w_credit_ok;
  logic               w_req_valid;
  logic               w_fire;
  logic               w_rden;
  logic               w_pop;
  logic               w_clear;

  // Credit is judged on the registered count only: a same-cycle ack frees nothing yet.
  assign w_run       = (r_state == RUN);
  assign w_cnt_zero  = (w_cnt == '0);
  assign w_credit_ok = (w_cnt < CNT_W'(MAX_OUTSTANDING));
  assign w_req_valid = r_hold_vld & w_credit_ok & w_run & (~r_hold.ordered | w_cnt_zero);
  assign w_fire      = w_req_valid & i_mem_req_ready;
  // An ordered store leaving the hold must not pull its successor in behind it.
  assign w_rden      = i_reset_n & w_run & (~r_hold_vld | (w_fire & ~r_hold.ordered));
  assign w_pop       = w_rden & i_fifo_valid;
  assign w_clear     = i_fifo_empty & ~r_hold_vld & w_cnt_zero;

  tt_store_credit_cnt #(.MAX(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_credit (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (w_fire),
    .i_dec     (i_mem_ack),
    .o_cnt     (w_cnt),
    .o_err     (w_err)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= RUN;
    else            r_state <= w_state_nxt;
  end

  // Next state: an ordered issue parks the sequencer until its ack returns.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_fire & r_hold.ordered) w_state_nxt = ORD_ACK;
      ORD_ACK: if (i_mem_ack)               w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Holding register: load on pop, free on fire; payload only changes on a pop.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_pop) begin
      r_hold.data    <= i_fifo_data;
      r_hold.addr    <= i_fifo_addr;
      r_hold.byten   <= i_fifo_byten;
      r_hold.ordered <= i_fifo_ordered;
      r_hold.ldst_sz <= i_fifo_ldst_sz;
      r_hold_vld     <= 1'b1;
    end else if (w_fire) begin
      r_hold_vld <= 1'b0;
    end
  end

  // Drain flags: a new request in the clear cycle re-arms the flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_fence_pend <= 1'b0;
      r_haz_pend   <= 1'b0;
    end else begin
      r_fence_pend <= i_fence_req   | (r_fence_pend & ~w_clear);
      r_haz_pend   <= i_load_cmphit | (r_haz_pend   & ~w_clear);
    end
  end

  assign o_fifo_rden       = w_rden;
  assign o_exit_merge_mode = r_fence_pend | r_haz_pend;
  assign o_mem_req_valid   = w_req_valid;
  assign o_mem_req_data    = r_hold.data;
  assign o_mem_req_addr    = r_hold.addr;
  assign o_mem_req_byten   = r_hold.byten;
  assign o_mem_req_ldst_sz = r_hold.ldst_sz;
  assign o_fence_done      = r_fence_pend & w_clear;
  assign o_load_stall      = i_load_cmphit | r_haz_pend;
  assign o_outstanding     = w_cnt;
  assign o_idle            = w_clear & w_run;
  assign o_err_ack         = w_err;
endmodule

// File: tb/tb_tt_store_drain_ctrl.sv
// Bench for tt_store_drain_ctrl: queue-based reference model plus directed scenarios.
module tb_tt_store_drain_ctrl;
  localparam int MAXO = 4;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_fifo_valid = 1'b0;
  logic [31:0] i_fifo_data = '0;
  logic [47:0] i_fifo_addr = '0;
  logic [3:0]  i_fifo_byten = '0;
  logic        i_fifo_ordered = 1'b0;
  logic [2:0]  i_fifo_ldst_sz = '0;
  logic        i_fifo_empty = 1'b1;
  logic        o_fifo_rden, o_exit_merge_mode, o_mem_req_valid;
  logic        i_mem_req_ready = 1'b0;
  logic [31:0] o_mem_req_data;
  logic [47:0] o_mem_req_addr;
  logic [3:0]  o_mem_req_byten;
  logic [2:0]  o_mem_req_ldst_sz;
  logic        i_mem_ack = 1'b0, i_load_cmphit = 1'b0, i_fence_req = 1'b0;
  logic        o_fence_done, o_load_stall, o_idle, o_err_ack;
  logic [2:0]  o_outstanding;

  tt_store_drain_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_fifo_valid(i_fifo_valid), .i_fifo_data(i_fifo_data), .i_fifo_addr(i_fifo_addr),
    .i_fifo_byten(i_fifo_byten), .i_fifo_ordered(i_fifo_ordered), .i_fifo_ldst_sz(i_fifo_ldst_sz),
    .i_fifo_empty(i_fifo_empty), .o_fifo_rden(o_fifo_rden), .o_exit_merge_mode(o_exit_merge_mode),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_data(o_mem_req_data), .o_mem_req_addr(o_mem_req_addr),
    .o_mem_req_byten(o_mem_req_byten), .o_mem_req_ldst_sz(o_mem_req_ldst_sz),
    .i_mem_ack(i_mem_ack), .i_load_cmphit(i_load_cmphit), .i_fence_req(i_fence_req),
    .o_fence_done(o_fence_done), .o_load_stall(o_load_stall), .o_outstanding(o_outstanding),
    .o_idle(o_idle), .o_err_ack(o_err_ack)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] d;
    logic [47:0] a;
    logic [3:0]  be;
    logic        ord;
    logic [2:0]  sz;
  } ent_t;

  // Reference model: FIFO contents, hold slot, outstanding count, ordered-block, drain flags.
  ent_t fq[$];
  ent_t hq[$];
  int   mcnt;
  bit   mblk, mfen, mhaz, merr;
  int   ncmp, nerr;
  int   dfire, dndone;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input bit ord);
    ent_t e;
    e.d = $urandom; e.a = {16'($urandom), 32'($urandom)};
    e.be = 4'($urandom); e.ord = ord; e.sz = 3'($urandom);
    fq.push_back(e);
  endtask

  // One clock: drive inputs, predict outputs from the model, compare, then advance the model.
  task automatic step(input bit rdy, input bit ack, input bit fen, input bit hit);
    bit mv, fire, rd, pop, clr, hord;
    int ncnt;
    i_mem_req_ready = rdy; i_mem_ack = ack; i_fence_req = fen; i_load_cmphit = hit;
    hord = (hq.size() == 1) && hq[0].ord;
    mv   = (hq.size() == 1) && (mcnt < MAXO) && !mblk && (!hord || mcnt == 0);
    fire = mv && rdy;
    rd   = !mblk && ((hq.size() == 0) || (fire && !hord));
    pop  = rd && (fq.size() > 0);
    clr  = (fq.size() == 0) && (hq.size() == 0) && (mcnt == 0);
    i_fifo_empty = (fq.size() == 0);
    i_fifo_valid = pop;
    if (pop) begin
      i_fifo_data = fq[0].d; i_fifo_addr = fq[0].a; i_fifo_byten = fq[0].be;
      i_fifo_ordered = fq[0].ord; i_fifo_ldst_sz = fq[0].sz;
    end else begin
      i_fifo_data = $urandom; i_fifo_addr = 48'($urandom); i_fifo_byten = 4'($urandom);
      i_fifo_ordered = 1'($urandom); i_fifo_ldst_sz = 3'($urandom);
    end
    #1;
    chk("req_valid", o_mem_req_valid, mv);
    chk("fifo_rden", o_fifo_rden, rd);
    chk("outstanding", o_outstanding, mcnt);
    chk("exit_merge", o_exit_merge_mode, mfen || mhaz);
    chk("fence_done", o_fence_done, mfen && clr);
    chk("load_stall", o_load_stall, hit || mhaz);
    chk("idle", o_idle, clr && !mblk);
    chk("err_ack", o_err_ack, merr);
    if (mv) begin
      chk("req_data", o_mem_req_data, hq[0].d);
      chk("req_addr", o_mem_req_addr, hq[0].a);
      chk("req_byten", o_mem_req_byten, hq[0].be);
      chk("req_sz", o_mem_req_ldst_sz, hq[0].sz);
    end
    if (o_mem_req_valid && rdy) dfire++;
    if (o_fence_done) dndone++;
    @(posedge i_clk);
    ncnt = mcnt + (fire ? 1 : 0) - ((ack && mcnt != 0) ? 1 : 0);
    if (ack && mcnt == 0) merr = 1;
    mcnt = ncnt;
    if (mblk && ack) mblk = 0;
    else if (fire && hord) mblk = 1;
    if (fire) void'(hq.pop_front());
    if (pop) hq.push_back(fq.pop_front());
    mfen = fen || (mfen && !clr);
    mhaz = hit || (mhaz && !clr);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_reset_n = 0; i_fifo_valid = 0; i_mem_ack = 0; i_fence_req = 0;
    i_load_cmphit = 0; i_mem_req_ready = 0; i_fifo_empty = (fq.size() == 0);
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    chk("rst_valid", o_mem_req_valid, 0);
    chk("rst_rden", o_fifo_rden, 0);
    chk("rst_cnt", o_outstanding, 0);
    chk("rst_err", o_err_ack, 0);
    chk("rst_exit", o_exit_merge_mode, 0);
    chk("rst_done", o_fence_done, 0);
    chk("rst_stall", o_load_stall, 0);
    chk("rst_addr", o_mem_req_addr, 0);
    chk("rst_data", o_mem_req_data, 0);
    chk("rst_idle", o_idle, fq.size() == 0);
    i_reset_n = 1;
    fq.delete(); hq.delete();
    mcnt = 0; mblk = 0; mfen = 0; mhaz = 0; merr = 0;
    i_fifo_empty = 1;
  endtask

  task automatic drain();
    int n = 0;
    while (!(fq.size() == 0 && hq.size() == 0 && mcnt == 0 && !mblk) && n < 300) begin
      step(1, (mcnt > 0) && ($urandom_range(1, 0) == 1), 0, 0);
      n++;
    end
    chk("drain_timeout", n < 300, 1);
  endtask

  initial begin
    int f0, d0, n;
    ent_t e0;
    ncmp = 0; nerr = 0; dfire = 0; dndone = 0;
    @(negedge i_clk);
    do_reset();
    chk("post_rst_idle", o_idle, 1);

    // Credit limit: no acks -> exactly MAXO fires; an ack frees credit one cycle later.
    for (int i = 0; i < 6; i++) push(0);
    f0 = dfire;
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
    chk("credit_fires", dfire - f0, 4);
    chk("credit_cnt", o_outstanding, 4);
    chk("credit_valid_low", o_mem_req_valid, 0);
    step(1, 1, 0, 0);
    chk("credit_no_same_cycle", dfire - f0, 4);
    step(1, 0, 0, 0);
    chk("credit_fire_next", dfire - f0, 5);
    drain();

    // Ordered: A unordered, B ordered, C unordered, A left unacked.
    push(0); push(1); push(0);
    f0 = dfire;
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("ord_only_a", dfire - f0, 1);
    chk("ord_b_wait_valid", o_mem_req_valid, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("ord_b_fired", dfire - f0, 2);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("ord_c_blocked", dfire - f0, 2);
    chk("ord_no_rden", o_fifo_rden, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("ord_c_fired", dfire - f0, 3);
    drain();

    // Backpressure: payload held, no pops, count steady.
    push(0); push(0);
    e0 = fq[0];
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      chk("bp_valid", o_mem_req_valid, 1);
      chk("bp_rden", o_fifo_rden, 0);
      chk("bp_addr", o_mem_req_addr, e0.a);
      chk("bp_data", o_mem_req_data, e0.d);
      chk("bp_cnt", o_outstanding, 0);
    end
    drain();

    // Fence with stores queued and outstanding.
    for (int i = 0; i < 5; i++) push(0);
    n = 0;
    while (mcnt < 2 && n < 10) begin step(1, 0, 0, 0); n++; end
    chk("fence_setup", o_outstanding, 2);
    d0 = dndone;
    step(0, 0, 1, 0);
    chk("fence_exit_merge", o_exit_merge_mode, 1);
    drain();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("fence_one_pulse", dndone - d0, 1);
    step(0, 0, 1, 0);
    chk("fence_idle_done", o_fence_done, 1);
    step(0, 0, 0, 0);
    chk("fence_idle_pulses", dndone - d0, 2);

    // Hazard while idle: stall held by the pending flag after cmphit drops.
    step(0, 0, 0, 1);
    i_load_cmphit = 0;
    #1;
    chk("haz_stall_pend", o_load_stall, 1);
    step(0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(2, 0) == 0 && fq.size() < 4) push($urandom_range(4, 0) == 0);
      step($urandom_range(3, 0) != 0, (mcnt > 0) && ($urandom_range(2, 0) == 0),
           $urandom_range(39, 0) == 0, $urandom_range(19, 0) == 0);
    end
    drain();
    step(0, 0, 0, 0);

    // Spurious ack: sticky error.
    step(0, 1, 0, 0);
    chk("err_set", o_err_ack, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("err_sticky", o_err_ack, 1);
    chk("err_cnt_zero", o_outstanding, 0);

    // Reset mid-stream.
    for (int i = 0; i < 4; i++) push(0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0);
    chk("post_rst2_err", o_err_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
